// File: rtl/amm_tg_pkg.sv
// Shared definitions for the Avalon-MM traffic generator/checker.
//   tg_state_e : FSM state encoding
//   MODE_*     : cfg_mode encodings
//   pat_lane() : 32-bit pattern value for (seed, global beat index, lane)
package amm_tg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_BURST,
    ST_RD_CMD,
    ST_RD_WAIT,
    ST_DONE
  } tg_state_e;

  localparam logic [1:0] MODE_WR    = 2'd0;
  localparam logic [1:0] MODE_RD    = 2'd1;
  localparam logic [1:0] MODE_WR_RD = 2'd2;
  localparam logic [1:0] MODE_RSVD  = 2'd3;

  function automatic logic [31:0] pat_lane(input logic [31:0] seed,
                                           input logic [31:0] k,
                                           input int unsigned lane);
    return seed + k + 32'(lane);
  endfunction

endpackage

// File: rtl/amm_pattern_gen.sv
// Builds one full data beat of the deterministic test pattern.
//   seed_i : pattern seed
//   k_i    : global beat index
//   beat_o : DATA_W-bit beat, lane j = seed + k + j
module amm_pattern_gen
  import amm_tg_pkg::*;
#(
  parameter int DATA_W = 320
) (
  input  logic [31:0]       seed_i,
  input  logic [31:0]       k_i,
  output logic [DATA_W-1:0] beat_o
);

  always_comb begin
    beat_o = '0;
    for (int j = 0; j < DATA_W / 32; j++) begin
      beat_o[j*32 +: 32] = pat_lane(seed_i, k_i, j);
    end
  end

endmodule

// File: rtl/amm_traffic_gen.sv
// Avalon-MM traffic generator and checker for the EMIF user port.
// Writes N bursts of L beats of a seeded pattern, reads them back, counts
// mismatching beats and reports pass/fail.
//   emif_usr_clk / emif_usr_reset_n : clock, async active-low reset
//   start, cfg_*                    : run request and configuration
//   amm_*                           : Avalon-MM master (registered outputs)
//   busy, done, pass, timeout       : run status
//   err_cnt, first_err_beat         : checker results
//
// state       | meaning
// ST_IDLE     | waiting for start, config sampled on start
// ST_WR_BURST | streaming write beats, amm_write held high
// ST_RD_CMD   | issuing back-to-back read commands, beats may return
// ST_RD_WAIT  | all commands issued, collecting remaining beats
// ST_DONE     | one-cycle done pulse, results held
module amm_traffic_gen
  import amm_tg_pkg::*;
#(
  parameter int DATA_W      = 320,
  parameter int ADDR_W      = 25,
  parameter int BURST_W     = 7,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                emif_usr_clk,
  input  logic                emif_usr_reset_n,
  input  logic                start,
  input  logic [1:0]          cfg_mode,
  input  logic [ADDR_W-1:0]   cfg_base_addr,
  input  logic [BURST_W-1:0]  cfg_burst_len,
  input  logic [CNT_W-1:0]    cfg_num_bursts,
  input  logic [31:0]         cfg_seed,
  input  logic                amm_ready,
  output logic                amm_read,
  output logic                amm_write,
  output logic [ADDR_W-1:0]   amm_address,
  output logic [BURST_W-1:0]  amm_burstcount,
  output logic [DATA_W-1:0]   amm_writedata,
  output logic [DATA_W/8-1:0] amm_byteenable,
  input  logic [DATA_W-1:0]   amm_readdata,
  input  logic                amm_readdatavalid,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                timeout,
  output logic [CNT_W-1:0]    err_cnt,
  output logic [31:0]         first_err_beat
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_RELOAD = TMO_W'(TIMEOUT_CYC - 1);

  tg_state_e state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [ADDR_W-1:0]  base_q, base_d, addr_q, addr_d;
  logic [BURST_W-1:0] len_q, len_d, bcnt_q, bcnt_d, beat_q, beat_d;
  logic [CNT_W-1:0]   nbursts_q, nbursts_d, burst_q, burst_d, err_cnt_q, err_cnt_d;
  logic [31:0]        seed_q, seed_d, total_q, total_d, issued_q, issued_d;
  logic [31:0]        wr_k_q, wr_k_d, rd_k_q, rd_k_d, first_err_q, first_err_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               amm_write_q, amm_write_d, amm_read_q, amm_read_d;
  logic               timeout_q, timeout_d, pass_q, pass_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;

  logic [31:0]        wgen_seed, wgen_k;
  logic [DATA_W-1:0]  wgen_beat, exp_beat;
  logic wr_xfer, rd_xfer, last_beat, last_burst, cfg_zero, readback;
  logic chk_en, all_rcvd, outstanding, tmo_hit;

  // Write data for the beat after the current one; seeded directly from
  // the config inputs when launching out of IDLE.
  assign wgen_seed = (state_q == ST_IDLE) ? cfg_seed : seed_q;
  assign wgen_k    = (state_q == ST_IDLE) ? 32'd0 : wr_k_q + 32'd1;

  amm_pattern_gen #(.DATA_W(DATA_W)) u_wr_pat (
    .seed_i(wgen_seed), .k_i(wgen_k), .beat_o(wgen_beat)
  );
  amm_pattern_gen #(.DATA_W(DATA_W)) u_rd_pat (
    .seed_i(seed_q), .k_i(rd_k_q), .beat_o(exp_beat)
  );

  assign wr_xfer    = amm_write_q & amm_ready;
  assign rd_xfer    = amm_read_q & amm_ready;
  assign last_beat  = (beat_q == len_q - 1'b1);
  assign last_burst = (burst_q == nbursts_q - 1'b1);
  assign cfg_zero   = (cfg_burst_len == '0) || (cfg_num_bursts == '0);
  assign readback   = (mode_q == MODE_WR_RD) || (mode_q == MODE_RSVD);
  assign chk_en     = amm_readdatavalid & ((state_q == ST_RD_CMD) || (state_q == ST_RD_WAIT));
  assign all_rcvd   = ((rd_k_q + 32'(chk_en)) == total_q);
  assign outstanding = ((state_q == ST_RD_CMD) || (state_q == ST_RD_WAIT)) && (issued_q != rd_k_q);
  assign tmo_hit    = outstanding && !amm_readdatavalid && (tmo_cnt_q == '0);

  always_ff @(posedge emif_usr_clk or negedge emif_usr_reset_n) begin
    if (!emif_usr_reset_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= '0;
      base_q      <= '0;
      len_q       <= '0;
      nbursts_q   <= '0;
      seed_q      <= '0;
      total_q     <= '0;
      addr_q      <= '0;
      bcnt_q      <= '0;
      wdata_q     <= '0;
      amm_write_q <= 1'b0;
      amm_read_q  <= 1'b0;
      beat_q      <= '0;
      burst_q     <= '0;
      wr_k_q      <= '0;
      rd_k_q      <= '0;
      issued_q    <= '0;
      tmo_cnt_q   <= TMO_RELOAD;
      timeout_q   <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      base_q      <= base_d;
      len_q       <= len_d;
      nbursts_q   <= nbursts_d;
      seed_q      <= seed_d;
      total_q     <= total_d;
      addr_q      <= addr_d;
      bcnt_q      <= bcnt_d;
      wdata_q     <= wdata_d;
      amm_write_q <= amm_write_d;
      amm_read_q  <= amm_read_d;
      beat_q      <= beat_d;
      burst_q     <= burst_d;
      wr_k_q      <= wr_k_d;
      rd_k_q      <= rd_k_d;
      issued_q    <= issued_d;
      tmo_cnt_q   <= tmo_cnt_d;
      timeout_q   <= timeout_d;
      pass_q      <= pass_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_zero)                 state_d = ST_DONE;
          else if (cfg_mode == MODE_RD) state_d = ST_RD_CMD;
          else                          state_d = ST_WR_BURST;
        end
      end
      ST_WR_BURST: begin
        if (wr_xfer && last_beat && last_burst) state_d = readback ? ST_RD_CMD : ST_DONE;
      end
      ST_RD_CMD: begin
        if (tmo_hit)                    state_d = ST_DONE;
        else if (rd_xfer && last_burst) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (all_rcvd || tmo_hit) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mode_d      = mode_q;
    base_d      = base_q;
    len_d       = len_q;
    nbursts_d   = nbursts_q;
    seed_d      = seed_q;
    total_d     = total_q;
    addr_d      = addr_q;
    bcnt_d      = bcnt_q;
    wdata_d     = wdata_q;
    amm_write_d = amm_write_q;
    amm_read_d  = amm_read_q;
    beat_d      = beat_q;
    burst_d     = burst_q;
    wr_k_d      = wr_k_q;
    rd_k_d      = rd_k_q;
    issued_d    = issued_q;
    tmo_cnt_d   = tmo_cnt_q;
    timeout_d   = timeout_q;
    pass_d      = pass_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d      = cfg_mode;
          base_d      = cfg_base_addr;
          len_d       = cfg_burst_len;
          nbursts_d   = cfg_num_bursts;
          seed_d      = cfg_seed;
          total_d     = 32'(cfg_num_bursts) * 32'(cfg_burst_len);
          addr_d      = cfg_base_addr;
          bcnt_d      = cfg_burst_len;
          wdata_d     = wgen_beat;
          beat_d      = '0;
          burst_d     = '0;
          wr_k_d      = '0;
          rd_k_d      = '0;
          issued_d    = '0;
          timeout_d   = 1'b0;
          err_cnt_d   = '0;
          first_err_d = '0;
          pass_d      = cfg_zero;
          amm_write_d = !cfg_zero && (cfg_mode != MODE_RD);
          amm_read_d  = !cfg_zero && (cfg_mode == MODE_RD);
        end
      end
      ST_WR_BURST: begin
        if (wr_xfer) begin
          wr_k_d  = wr_k_q + 32'd1;
          wdata_d = wgen_beat;
          beat_d  = beat_q + 1'b1;
          if (last_beat) begin
            beat_d = '0;
            if (last_burst) begin
              amm_write_d = 1'b0;
              burst_d     = '0;
              addr_d      = base_q;
              amm_read_d  = readback;
            end else begin
              burst_d = burst_q + 1'b1;
              addr_d  = addr_q + ADDR_W'(len_q);
            end
          end
        end
      end
      ST_RD_CMD: begin
        if (rd_xfer) begin
          issued_d = issued_q + 32'(len_q);
          if (last_burst) begin
            amm_read_d = 1'b0;
          end else begin
            burst_d = burst_q + 1'b1;
            addr_d  = addr_q + ADDR_W'(len_q);
          end
        end
        if (tmo_hit) amm_read_d = 1'b0;
      end
      default: ;
    endcase

    if (chk_en) begin
      rd_k_d = rd_k_q + 32'd1;
      if (amm_readdata != exp_beat) begin
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
        if (err_cnt_q == '0) first_err_d = rd_k_q;
      end
    end

    // Idle-cycle watchdog: reloads on every returned beat and whenever
    // nothing is outstanding, counts down otherwise.
    if (chk_en || !outstanding)   tmo_cnt_d = TMO_RELOAD;
    else if (tmo_cnt_q != '0)     tmo_cnt_d = tmo_cnt_q - 1'b1;
    if (tmo_hit) timeout_d = 1'b1;

    // Result is resolved on the same edge that enters DONE so pass is
    // already valid while done is high.
    if (state_d == ST_DONE && state_q != ST_IDLE && state_q != ST_DONE) begin
      pass_d = (err_cnt_d == '0) && !timeout_d;
    end
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
  end

  assign amm_write      = amm_write_q;
  assign amm_read       = amm_read_q;
  assign amm_address    = addr_q;
  assign amm_burstcount = bcnt_q;
  assign amm_writedata  = wdata_q;
  assign amm_byteenable = '1;
  assign pass           = pass_q;
  assign timeout        = timeout_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_beat = first_err_q;

endmodule

// File: doc/amm_traffic_gen.md
# amm_traffic_gen

Parametrised Avalon-MM traffic generator and checker for the EMIF user port. On a start pulse it writes a configurable number of bursts of a deterministic pattern, reads them back, compares every returned beat, and reports pass/fail, error count and first failing beat. It sits between the debug source/probe block and the EMIF `amm_*_0` port, in the `emif_usr_clk` domain.

## Interface
- `DATA_W`, 320, data width in bits; must be a multiple of 32.
- `ADDR_W`, 25, word-address width.
- `BURST_W`, 7, burstcount width.
- `CNT_W`, 16, width of `cfg_num_bursts` and `err_cnt`.
- `TIMEOUT_CYC`, 4096, idle cycles allowed while read beats are outstanding.

Ports (direction, width, meaning):
- `emif_usr_clk` in 1: sole clock.
- `emif_usr_reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle start pulse; ignored while `busy`.
- `cfg_mode` in 2: 0 = write-only, 1 = read-only, 2 = write then read, 3 = reserved (treated as 2).
- `cfg_base_addr` in ADDR_W: first word address.
- `cfg_burst_len` in BURST_W: beats per burst.
- `cfg_num_bursts` in CNT_W: number of bursts.
- `cfg_seed` in 32: pattern seed.
- `amm_ready` in 1: slave ready (inverse waitrequest).
- `amm_read` out 1, `amm_write` out 1.
- `amm_address` out ADDR_W, `amm_burstcount` out BURST_W.
- `amm_writedata` out DATA_W, `amm_byteenable` out DATA_W/8 (all ones).
- `amm_readdata` in DATA_W, `amm_readdatavalid` in 1.
- `busy` out 1, `done` out 1 (one-cycle pulse), `pass` out 1, `timeout` out 1.
- `err_cnt` out CNT_W, `first_err_beat` out 32.

## Operation
- States: IDLE, WR_BURST, RD_CMD, RD_WAIT, DONE.
- Config is sampled on `start` and held internally. `start` with `cfg_burst_len`=0 or `cfg_num_bursts`=0 goes IDLE→DONE: `pass`=1, `err_cnt`=0.
- Burst i uses address `cfg_base_addr + i*cfg_burst_len`, with modulo 2^ADDR_W wrap.
- Global beat index k runs 0..N·L−1, where N = bursts and L = burst length.
- Pattern: 32-bit lane j of beat k = `cfg_seed + k + j`, taken mod 2^32.
- WR_BURST:
  - `amm_write` is held high; a beat transfers when `amm_write & amm_ready`.
  - Address and burstcount are presented on every beat of the burst and are constant within the burst.
  - Data advances only on a transferred beat.
  - After the last beat of the last burst: go to RD_CMD for mode 2, or DONE for mode 0.
  - Mode 1 enters RD_CMD directly.
- RD_CMD:
  - `amm_read` is high with address and burstcount; the command transfers on `amm_ready`.
  - The next command is issued in the following cycle; commands are back-to-back.
  - After the last command: go to RD_WAIT.
  - Read beats may return while still in RD_CMD and are checked there.
- Checking:
  - Each `amm_readdatavalid` beat is compared with the pattern for the expected beat index k, which increments per valid beat.
  - On mismatch, `err_cnt` increments and saturates at all-ones.
  - The first mismatch latches k into `first_err_beat`.
- RD_WAIT: leave for DONE when all N·L beats have been received.
- Timeout: a timeout counter runs while beats are outstanding and resets on each valid beat. Reaching TIMEOUT_CYC sets `timeout`=1 and goes to DONE.
- DONE:
  - Pulse `done` for one cycle, then return to IDLE.
  - `pass` = (`err_cnt`==0 && !`timeout`).
  - `pass`, `err_cnt`, `first_err_beat` and `timeout` hold until the next accepted `start`, which clears them.

## Timing
- Reset: every output is 0 except `amm_byteenable` (all ones).
- `amm_write`/`amm_read` assert on the cycle after the accepted `start` edge; there is no command bubble between bursts.
- All Avalon outputs are registered. They are held stable while `amm_ready`=0.
- Compare latency: one cycle from `amm_readdatavalid` to the `err_cnt` update. `done` asserts after the final compare has been registered.
- Read data arriving while in IDLE is ignored.
- `amm_readdatavalid` and `amm_ready` may both be active in the same cycle; both are processed.
- Reset mid-operation: everything returns to reset values immediately; no partial burst completes.

## Structure
- Package `amm_tg_pkg` holds:
  - the state encoding;
  - the mode constants;
  - the pattern function (seed, beat index, lane) → 32-bit lane value.
- Sub-module `amm_pattern_gen` (DATA_W parameter) builds one full beat from seed and k. It is instantiated twice: once for write data and once for expected read data.

## Test plan
- Mode 2, base 0, L=6, N=2, seed 0x3F3F3F3F, ideal slave → 12 writes to addresses 0 and 6, 12 beats read back, `pass`=1, `err_cnt`=0.
- Same run with the slave dropping `amm_ready` randomly 50% of cycles → address, burstcount and data stay stable during stalls; `pass`=1.
- Mode 1 with the slave corrupting beat 7, lane 0 → `err_cnt`=1, `first_err_beat`=7, `pass`=0.
- Mode 2, L=4, N=3, slave returns only 11 beats → `timeout`=1 exactly TIMEOUT_CYC cycles after the last beat; `pass`=0.
- Base 0x1FFFFFC, L=4, N=2 → second burst address is 0x0000000 (wrap).
- `emif_usr_reset_n` asserted mid-burst, then `start` with `cfg_num_bursts`=0 → all outputs return to reset values; one cycle later `done` pulses with `pass`=1.
